// File: rtl/tables_lut.sv
// Registered 3-input truth-table evaluator with a runtime-writable table
// and a saturating counter of output transitions.
module tables_lut #(
  parameter logic [7:0]  INIT  = 8'hE8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_data,
  output logic             z,
  output logic [7:0]       cfg_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [7:0] tbl;
  logic [2:0] idx;
  logic       z_next;

  assign idx    = {w, x, y};
  // Lookup reads the table as it stood before this edge's write.
  assign z_next = tbl[idx];
  assign cfg_q  = tbl;

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl        <= INIT;
      z          <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      z <= z_next;
      if (cfg_we)
        tbl <= cfg_data;
      if ((z_next != z) && (toggle_cnt != '1))
        toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tables_lut.sv
// Scoreboard bench for tables_lut: one default build plus a CNT_W=4 build
// sharing the same stimulus so counter saturation is reachable quickly.
module tb_tables_lut;

  logic        clk = 1'b0;
  logic        rst, w, x, y, cfg_we;
  logic [7:0]  cfg_data;
  logic        z, z4;
  logic [7:0]  cfg_q, cfg_q4;
  logic [15:0] toggle_cnt;
  logic [3:0]  toggle_cnt4;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    logic        z;
    logic [7:0]  cfgq;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [7:0]  m_tbl = 8'hE8;
  logic        m_z = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;

  always #5 clk = ~clk;

  tables_lut dut (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .z(z), .cfg_q(cfg_q), .toggle_cnt(toggle_cnt)
  );

  tables_lut #(.INIT(8'hE8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .w(w), .x(x), .y(y),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .z(z4), .cfg_q(cfg_q4), .toggle_cnt(toggle_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic cyc(input logic iw, input logic ix, input logic iy,
                     input logic we, input logic [7:0] d, input logic r,
                     input string tag);
    exp_t e;
    logic nz;
    w = iw; x = ix; y = iy; cfg_we = we; cfg_data = d; rst = r;
    if (r) begin
      nz = 1'b0;
      m_tbl = 8'hE8;
      m_cnt = '0;
      m_cnt4 = '0;
    end else begin
      nz = m_tbl[{iw, ix, iy}];
      if (nz != m_z) begin
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (m_cnt4 != 4'hF) m_cnt4++;
      end
      if (we) m_tbl = d;
    end
    m_z = nz;
    e.z = nz; e.cfgq = m_tbl; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".z"},      32'(z),           32'(e.z));
    chk({tag, ".z4"},     32'(z4),          32'(e.z));
    chk({tag, ".cfg_q"},  32'(cfg_q),       32'(e.cfgq));
    chk({tag, ".cnt"},    32'(toggle_cnt),  32'(e.cnt));
    chk({tag, ".cnt4"},   32'(toggle_cnt4), 32'(e.cnt4));
  endtask

  initial begin
    logic [2:0] seq [5];
    logic [2:0] v;
    seq[0] = 3'b000; seq[1] = 3'b100; seq[2] = 3'b101; seq[3] = 3'b111; seq[4] = 3'b110;

    // reset and idle lookup
    cyc(0, 0, 0, 0, 8'h00, 1, "rst0");
    cyc(0, 0, 0, 0, 8'h00, 1, "rst1");
    cyc(0, 0, 0, 0, 8'h00, 0, "idle");
    chk("reset_z", 32'(z), 32'd0);
    chk("reset_cfg_q", 32'(cfg_q), 32'hE8);
    chk("reset_cnt", 32'(toggle_cnt), 32'd0);

    // majority walk, each index held two cycles
    for (int i = 0; i < 5; i++) begin
      v = seq[i];
      cyc(v[2], v[1], v[0], 0, 8'h00, 0, "walk");
      cyc(v[2], v[1], v[0], 0, 8'h00, 0, "walk");
    end
    chk("walk_cnt", 32'(toggle_cnt), 32'd1);

    // write with idx 000: old table on the write edge, new table after
    cyc(0, 0, 0, 1, 8'h01, 0, "wr01");
    chk("wr_edge_z", 32'(z), 32'd0);
    chk("wr_cfg_q", 32'(cfg_q), 32'h01);
    cyc(0, 0, 0, 0, 8'h00, 0, "post_wr");
    chk("post_wr_z", 32'(z), 32'd1);

    // 8'h55 with y alternating: z toggles every cycle, 4-bit counter saturates
    cyc(0, 0, 1, 1, 8'h55, 0, "wr55");
    for (int i = 0; i < 24; i++)
      cyc(0, 0, logic'(i[0]), 0, 8'h00, 0, "alt");
    chk("sat_cnt4", 32'(toggle_cnt4), 32'hF);

    // reset wins over a simultaneous write
    cyc(1, 1, 1, 1, 8'h00, 1, "rst_we");
    chk("rst_we_z", 32'(z), 32'd0);
    chk("rst_we_cnt", 32'(toggle_cnt), 32'd0);
    chk("rst_we_cfg_q", 32'(cfg_q), 32'hE8);

    // exhaustive sweep against the majority function
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      cyc(v[2], v[1], v[0], 0, 8'h00, 0, "sweep");
      chk("sweep_maj", 32'(z), 32'(maj(v[2], v[1], v[0])));
    end

    if (sb.size() != 0) begin
      compared++;
      failed++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
